// File: rtl/btn_event_pkg.sv
// Shared types and constants for the button event decoder.
// Optional auto-repeat is controlled in btn_event_gen by BTN_AUTOREPEAT_EN.
package btn_event_pkg;

    // FSM state encoding for the event decoder.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    // Nominal system clock, used to derive default hold thresholds.
    localparam int DEFAULT_CLK_HZ = 100_000_000;

    // Converts a duration in milliseconds to clock cycles at DEFAULT_CLK_HZ.
    function automatic int ms_to_cycles(input int ms);
        return (DEFAULT_CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_event_gen.sv
// Button event decoder: turns a debounced button level into one-cycle
// press / release / click / long / repeat events plus a held level.
// Macro BTN_AUTOREPEAT_EN: when defined, LONG_HELD emits repeat_pulse every
// REPEAT_PERIOD cycles; when undefined repeat_pulse is 0 and the counter
// rests at 0 while long-held.
//
// Handshake: none. db_in is a plain synchronous level; every output is a
// registered level or single-cycle strobe with no backpressure.
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int CNT_WIDTH     = 27,
    parameter int LONG_THRESH   = ms_to_cycles(500),
    parameter int REPEAT_PERIOD = ms_to_cycles(100)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output btn_state_t dbg_state
);

    // Terminal counts: compare against threshold minus one so the counter
    // is cleared on the very edge the event fires and never wraps.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_THRESH - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);
`endif

    // Reject parameter sets whose thresholds do not fit the counter.
    generate
        if ((LONG_THRESH < 2) || (REPEAT_PERIOD < 2) ||
            (longint'(LONG_THRESH) >= (longint'(1) << CNT_WIDTH)) ||
            (longint'(REPEAT_PERIOD) >= (longint'(1) << CNT_WIDTH))) begin : g_bad_cfg
            $error("btn_event_gen: thresholds must be in [2, 2**CNT_WIDTH)");
        end
    endgenerate

    btn_state_t           r_state;
    btn_state_t           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    logic w_press_nxt;
    logic w_release_nxt;
    logic w_click_nxt;
    logic w_long_nxt;
    logic w_repeat_nxt;
    logic w_held_nxt;

    logic r_press;
    logic r_release;
    logic r_click;
    logic r_long;
    logic r_repeat;
    logic r_held;

    // State and hold-time counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and counter; a release always wins over a threshold hit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (db_in) begin
                    w_state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!db_in) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = LONG_HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                end
            end
            LONG_HELD: begin
                if (!db_in) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (r_cnt == REP_LAST) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                    end
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Event decode for the coming cycle, mirroring the transition priorities.
    always_comb begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_click_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_press_nxt = db_in;
            end
            PRESSED: begin
                if (!db_in) begin
                    w_release_nxt = 1'b1;
                    w_click_nxt   = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_long_nxt    = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!db_in) begin
                    w_release_nxt = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (r_cnt == REP_LAST) begin
                    w_repeat_nxt  = 1'b1;
                end
`endif
            end
            default: begin
                w_press_nxt = 1'b0;
            end
        endcase
        w_held_nxt = (w_state_nxt != IDLE);
    end

    // Output registers so every event is glitch-free and one cycle wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_click   <= w_click_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= w_held_nxt;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign click_pulse   = r_click;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;
    assign held          = r_held;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with LONG_THRESH=8, REPEAT_PERIOD=4,
// CNT_WIDTH=4. Repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_btn_event_gen;
    import btn_event_pkg::*;

    localparam int CW = 4;
    localparam int LT = 8;
    localparam int RP = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    // Output vector order: {press, release, click, long, repeat, held}
    localparam logic [5:0] E_ZERO  = 6'b000000;
    localparam logic [5:0] E_PRESS = 6'b100001;
    localparam logic [5:0] E_HELD  = 6'b000001;
    localparam logic [5:0] E_LONG  = 6'b000101;
    localparam logic [5:0] E_REP   = 6'b000011;
    localparam logic [5:0] E_CLICK = 6'b011000;
    localparam logic [5:0] E_REL   = 6'b010000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       db_in = 1'b0;
    logic       press_pulse;
    logic       release_pulse;
    logic       click_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    btn_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    btn_event_gen #(
        .CNT_WIDTH    (CW),
        .LONG_THRESH  (LT),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .db_in        (db_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click_pulse  (click_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .dbg_state    (dbg_state)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    logic [5:0] obs_v;
    assign obs_v = {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held};

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input btn_state_t obs, input btn_state_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed state=%0d expected state=%0d", tag, obs, exp);
        end
    endtask

    // Driver: present db_in for one edge, then check the registered outputs.
    task automatic tick(input logic d, input logic [5:0] exp, input string tag);
        db_in = d;
        @(posedge clk);
        #1;
        chk(tag, obs_v, exp);
    endtask

    // Pulse exclusivity: at most one primary event, click only with release.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1) &&
                    (!click_pulse || release_pulse)) else begin
                errors++;
                $error("FAIL exclusive: observed=%b expected at most one event", obs_v);
            end
        end
    end

    logic [5:0] exp_v;

    initial begin
        // Reset state, checked before any clock edge.
        #2;
        chk("reset_async", obs_v, E_ZERO);
        chk_state("reset_state", dbg_state, IDLE);
        db_in = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_held_in", obs_v, E_ZERO);
        db_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        tick(1'b0, E_ZERO, "idle");
        tick(1'b0, E_ZERO, "idle2");

        // Short press, 3 cycles high.
        tick(1'b1, E_PRESS, "short_press");
        tick(1'b1, E_HELD,  "short_held1");
        tick(1'b1, E_HELD,  "short_held2");
        tick(1'b0, E_CLICK, "short_release");
        tick(1'b0, E_ZERO,  "short_after");

        // Long press, 24 cycles high: long at 9th sample, repeats every 4 after.
        for (int i = 1; i <= 24; i++) begin
            if (i == 1)
                exp_v = E_PRESS;
            else if (i < 9)
                exp_v = E_HELD;
            else if (i == 9)
                exp_v = E_LONG;
            else if (AUTO_REP && (((i - 9) % RP) == 0))
                exp_v = E_REP;
            else
                exp_v = E_HELD;
            tick(1'b1, exp_v, $sformatf("long_hold_%0d", i));
        end
        chk_state("long_state", dbg_state, LONG_HELD);
        tick(1'b0, E_REL,  "long_release");
        tick(1'b0, E_ZERO, "long_after");
        chk_state("long_idle", dbg_state, IDLE);

        // Boundary: release on the sample where cnt == LT-1.
        tick(1'b1, E_PRESS, "bnd_press");
        for (int i = 2; i <= 8; i++) begin
            tick(1'b1, E_HELD, $sformatf("bnd_held_%0d", i));
        end
        tick(1'b0, E_CLICK, "bnd_release");
        tick(1'b0, E_ZERO,  "bnd_after");

        // Async reset at cycle 5 of a press, db_in stays high.
        tick(1'b1, E_PRESS, "rst_press");
        for (int i = 2; i <= 5; i++) begin
            tick(1'b1, E_HELD, $sformatf("rst_held_%0d", i));
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_async", obs_v, E_ZERO);
        chk_state("rst_mid_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, E_PRESS, "rst_repress");
        for (int i = 2; i <= 8; i++) begin
            tick(1'b1, E_HELD, $sformatf("rst_reheld_%0d", i));
        end
        tick(1'b1, E_LONG, "rst_long");
        tick(1'b1, E_HELD, "rst_post_long");
        tick(1'b0, E_REL,  "rst_release");
        tick(1'b0, E_ZERO, "rst_after");

        // Back-to-back single-cycle presses.
        tick(1'b1, E_PRESS, "b2b_press1");
        tick(1'b0, E_CLICK, "b2b_release1");
        tick(1'b1, E_PRESS, "b2b_press2");
        tick(1'b0, E_CLICK, "b2b_release2");
        tick(1'b0, E_ZERO,  "b2b_after");

        // Immediate re-press the cycle right after a release is seen.
        tick(1'b1, E_PRESS, "rep_press1");
        tick(1'b1, E_HELD,  "rep_held1");
        tick(1'b0, E_CLICK, "rep_release1");
        tick(1'b1, E_PRESS, "rep_press2");
        tick(1'b0, E_CLICK, "rep_release2");
        tick(1'b0, E_ZERO,  "rep_after");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
